spi_seq_arbiter: RTL and testbench
==================================

SPI_SEQ_ARBITER -- requirements
Module: spi_seq_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles enforced between the end of one SPI frame and the next start (legal range 1-255).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum WAIT_DONE cycles before a frame is aborted (legal range 40-65535).
REQ-003 Clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 Req0  input  1  requester 0 frame request, level, held until Ack0.
REQ-006 Data0  input  16  requester 0 frame word, MSB first on the wire.
REQ-007 Ack0  output  1  one-cycle pulse: requester 0 frame finished (done or timeout).
REQ-008 Req1  input  1  requester 1 frame request, level, held until Ack1.
REQ-009 Data1  input  16  requester 1 frame word.
REQ-010 Ack1  output  1  one-cycle pulse: requester 1 frame finished.
REQ-011 SpiData  output  16  word presented to the SPI master; registered.
REQ-012 SpiStart  output  1  one-cycle start pulse to the SPI master.
REQ-013 SpiDone  input  1  one-cycle completion pulse from the SPI master.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 GrantId  output  1  index of the requester currently or last granted.
REQ-016 TimeoutErr  output  1  one-cycle pulse coincident with the Ack of an aborted frame.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT_DONE and GAP.
REQ-018 IDLE: no Req -> stay; any Req -> latch granted Data into SpiData, set GrantId, go START.
REQ-019 Arbitration SHALL be round-robin: with both Req high, the requester not equal to LastGrant wins; with one Req high, that requester wins.
REQ-020 START: SpiStart=1 for exactly this one cycle, clear WAIT counter, go WAIT_DONE.
REQ-021 WAIT_DONE: counter increments by 1 per cycle; SpiDone=1 -> pulse Ack of GrantId next cycle, LastGrant<=GrantId, go GAP.
REQ-022 WAIT_DONE: counter reaching TIMEOUT_CYCLES without SpiDone -> pulse Ack of GrantId and TimeoutErr together, LastGrant<=GrantId, go GAP.
REQ-023 SpiDone and timeout in the same cycle -> treated as done; TimeoutErr stays 0.
REQ-024 GAP: count GAP_CYCLES cycles, then go IDLE; Req sampled only in IDLE.
REQ-025 Latency Req rising (FSM in IDLE) -> SpiStart = 2 cycles; SpiDone -> Ack = 1 cycle.
REQ-026 SpiDone in IDLE, START or GAP SHALL be ignored (no Ack, no state change).
REQ-027 Req dropped after grant: frame completes and Ack is still pulsed; Req dropped before grant: not served.
REQ-028 SpiData SHALL hold its value from grant until the next grant; Data inputs are not sampled outside the grant cycle.
REQ-029 Ack0 and Ack1 SHALL never be high in the same cycle; at most one Ack per SpiStart.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, SpiData=0, SpiStart=0, Ack0=Ack1=0, Busy=0, GrantId=0, TimeoutErr=0, counters=0, LastGrant=1 (requester 0 wins the first tie).
REQ-031 Reset mid-frame SHALL drop the frame without Ack; after release, pending Req are re-arbitrated from IDLE.

Verification
REQ-032 Req0=1, Data0=16'hA5C3, SpiDone 34 cycles after SpiStart -> SpiStart 2 cycles after Req0, SpiData=16'hA5C3, Ack0 one cycle after SpiDone, Busy low 4 cycles after GAP entry.
REQ-033 Req0 and Req1 high together, held continuously -> grant order 0,1,0,1 with Ack0/Ack1 alternating, never coincident.
REQ-034 Req1=1, SpiDone never asserted -> Ack1 and TimeoutErr pulse together 255 cycles after WAIT_DONE entry, then GAP, then IDLE.
REQ-035 SpiDone injected in IDLE and in GAP -> no Ack, no state change, Busy unchanged.
REQ-036 reset_n pulsed low during WAIT_DONE with Req0 held -> all outputs at reset values, no Ack0; after release a new SpiStart with Data0 follows 2 cycles later.
REQ-037 SpiDone on the same cycle the counter reaches TIMEOUT_CYCLES -> Ack pulses, TimeoutErr stays 0.

Source files
------------

// File: rtl/spi_seq_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_seq_arbiter_if
// Bundles the signals between two frame requesters, the arbiter and the
// SPI master.
//   Req0/Req1      level requests, held until the matching Ack
//   Data0/Data1    16-bit frame words, sampled only in the grant cycle
//   Ack0/Ack1      one-cycle frame-finished pulses (done or timeout)
//   SpiData        registered word presented to the SPI master
//   SpiStart       one-cycle start pulse to the SPI master
//   SpiDone        one-cycle completion pulse from the SPI master
//   Busy           arbiter is not idle
//   GrantId        requester currently or last granted
//   TimeoutErr     one-cycle pulse alongside the Ack of an aborted frame
// slave  : the arbiter's view.
// master : the environment's view (requesters plus SPI master).
// ---------------------------------------------------------------------------
interface spi_seq_arbiter_if;
  logic        Req0;
  logic [15:0] Data0;
  logic        Ack0;
  logic        Req1;
  logic [15:0] Data1;
  logic        Ack1;
  logic [15:0] SpiData;
  logic        SpiStart;
  logic        SpiDone;
  logic        Busy;
  logic        GrantId;
  logic        TimeoutErr;

  modport slave (
    input  Req0, Data0, Req1, Data1, SpiDone,
    output Ack0, Ack1, SpiData, SpiStart, Busy, GrantId, TimeoutErr
  );

  modport master (
    output Req0, Data0, Req1, Data1, SpiDone,
    input  Ack0, Ack1, SpiData, SpiStart, Busy, GrantId, TimeoutErr
  );
endinterface

// File: rtl/spi_seq_arbiter.sv
// ---------------------------------------------------------------------------
// spi_seq_arbiter
// Round-robin arbiter sequencing 16-bit frames from two requesters onto a
// single SPI master. Each frame:
//   IDLE -> grant (latch word, set GrantId)
//   START -> one-cycle SpiStart
//   WAIT_DONE -> wait for SpiDone or abort after TIMEOUT_CYCLES
//   GAP -> enforce GAP_CYCLES idle cycles before the next grant.
// Ports:
//   Clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      spi_seq_arbiter_if.slave (requests, acks, SPI handshake,
//            status outputs)
// Parameters:
//   GAP_CYCLES      idle cycles between frames (1..255)
//   TIMEOUT_CYCLES  WAIT_DONE cycles before a frame is aborted (40..65535)
// ---------------------------------------------------------------------------
module spi_seq_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               Clk,
  input logic               reset_n,
  spi_seq_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  // Terminal counts: the counter runs 0..LAST, so LAST+1 cycles are spent.
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] cycleCnt;
  logic        lastGrant;
  logic        grantId;
  logic [15:0] spiData;
  logic        spiStart;
  logic        ack0;
  logic        ack1;
  logic        timeoutErr;

  logic        anyReq;
  logic        winner;

  // Round-robin pick: on a tie the requester that was not served last wins;
  // otherwise the single active requester wins.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    anyReq = bus.Req0 | bus.Req1;
    winner = 1'b0;
    if (bus.Req0 && bus.Req1) begin
      winner = ~lastGrant;
    end else begin
      winner = bus.Req1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cycleCnt   <= '0;
      // lastGrant resets to 1 so requester 0 wins the first tie.
      lastGrant  <= 1'b1;
      grantId    <= 1'b0;
      spiData    <= '0;
      spiStart   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      // Pulse outputs default low; only the cycle that raises them sets them.
      spiStart   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      timeoutErr <= 1'b0;

      case (state)
        IDLE: begin
          if (anyReq) begin
            grantId <= winner;
            spiData <= winner ? bus.Data1 : bus.Data0;
            state   <= START;
          end
        end

        START: begin
          spiStart <= 1'b1;
          cycleCnt <= '0;
          state    <= WAIT_DONE;
        end

        WAIT_DONE: begin
          // SpiDone is tested first so a done arriving on the timeout cycle
          // completes the frame normally without TimeoutErr.
          if (bus.SpiDone || (cycleCnt == TIMEOUT_LAST)) begin
            ack0       <= ~grantId;
            ack1       <= grantId;
            timeoutErr <= ~bus.SpiDone;
            lastGrant  <= grantId;
            cycleCnt   <= '0;
            state      <= GAP;
          end else begin
            cycleCnt <= cycleCnt + 16'd1;
          end
        end

        GAP: begin
          if (cycleCnt == GAP_LAST) begin
            cycleCnt <= '0;
            state    <= IDLE;
          end else begin
            cycleCnt <= cycleCnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ack0       = ack0;
  assign bus.Ack1       = ack1;
  assign bus.SpiData    = spiData;
  assign bus.SpiStart   = spiStart;
  assign bus.Busy       = (state != IDLE);
  assign bus.GrantId    = grantId;
  assign bus.TimeoutErr = timeoutErr;

endmodule

// File: tb/tb_spi_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_seq_arbiter
// Drives both requesters and plays the SPI master. Expected grants, words,
// Ack/TimeoutErr timing and gap length come from a transaction-level model
// (last-served requester plus arithmetic on the SpiDone delay).
// ---------------------------------------------------------------------------
module tb_spi_seq_arbiter;

  localparam int GAP     = 4;
  localparam int TIMEOUT = 255;

  logic Clk;
  logic reset_n;

  spi_seq_arbiter_if bus ();

  spi_seq_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Model state: which requester finished a frame most recently.
  bit modelLast = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Runs one frame from IDLE with the current requests. d is the number of
  // cycles after SpiStart at which SpiDone is pulsed (d < 1 means never).
  task automatic serveFrame(input int d, input bit dropReq, input bit gapDone,
                            output bit obsGrant);
    bit          w;
    logic [15:0] expData;
    int          ackIdx;
    bit          tErr;
    logic [3:0]  expV;

    w       = (bus.Req0 && bus.Req1) ? ~modelLast : bus.Req1;
    expData = w ? bus.Data1 : bus.Data0;
    tErr    = !(d >= 1 && d < TIMEOUT);
    ackIdx  = tErr ? TIMEOUT : d + 1;

    tick();  // grant edge
    obsGrant = bus.GrantId;
    check("grant_id", 32'(bus.GrantId), 32'(w));
    check("grant_busy", 32'(bus.Busy), 32'd1);
    check("grant_spidata", 32'(bus.SpiData), 32'(expData));
    check("grant_nostart", 32'(bus.SpiStart), 32'd0);
    if (dropReq) begin
      bus.Req0 = 1'b0;
      bus.Req1 = 1'b0;
    end

    tick();  // SpiStart two edges after the request was sampled
    check("spi_start", 32'(bus.SpiStart), 32'd1);
    check("start_spidata", 32'(bus.SpiData), 32'(expData));

    for (int idx = 1; idx <= ackIdx; idx++) begin
      bus.Data0 = 16'($urandom);
      bus.Data1 = 16'($urandom);
      tick();
      expV = {(idx == ackIdx) && !w, (idx == ackIdx) && w,
              (idx == ackIdx) && tErr, 1'b0};
      check("frame_ack_terr_start",
            32'({bus.Ack0, bus.Ack1, bus.TimeoutErr, bus.SpiStart}), 32'(expV));
      if (idx == ackIdx) begin
        check("ack_busy", 32'(bus.Busy), 32'd1);
        check("hold_spidata", 32'(bus.SpiData), 32'(expData));
      end
      bus.SpiDone = (idx == d);
    end
    modelLast = w;

    for (int g = 1; g <= GAP; g++) begin
      tick();
      check("gap_busy", 32'(bus.Busy), 32'(g < GAP));
      check("gap_quiet",
            32'({bus.Ack0, bus.Ack1, bus.TimeoutErr, bus.SpiStart}), 32'd0);
      bus.SpiDone = gapDone && (g == 1);
    end
    bus.SpiDone = 1'b0;
  endtask

  initial begin
    bit g;

    bus.Req0    = 1'b0;
    bus.Req1    = 1'b0;
    bus.Data0   = 16'h0;
    bus.Data1   = 16'h0;
    bus.SpiDone = 1'b0;
    reset_n     = 1'b0;

    // Reset state.
    #1;
    check("rst_outputs",
          32'({bus.Ack0, bus.Ack1, bus.TimeoutErr, bus.SpiStart, bus.Busy, bus.GrantId}),
          32'd0);
    check("rst_spidata", 32'(bus.SpiData), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // SpiDone while IDLE is ignored.
    bus.SpiDone = 1'b1;
    tick();
    bus.SpiDone = 1'b0;
    check("idle_done_busy", 32'(bus.Busy), 32'd0);
    check("idle_done_acks", 32'({bus.Ack0, bus.Ack1, bus.TimeoutErr}), 32'd0);
    tick();
    check("idle_done_busy2", 32'(bus.Busy), 32'd0);

    // Single requester 0, SpiDone 34 cycles after SpiStart, SpiDone in GAP.
    bus.Req0  = 1'b1;
    bus.Data0 = 16'hA5C3;
    serveFrame(34, 1'b0, 1'b1, g);
    bus.Req0 = 1'b0;
    tick();
    check("after_gap_idle", 32'(bus.Busy), 32'd0);

    // Requester 1 alone, SpiDone never arrives: timeout abort.
    bus.Req1  = 1'b1;
    bus.Data1 = 16'h5A3C;
    serveFrame(0, 1'b0, 1'b0, g);
    bus.Req1 = 1'b0;

    // Both held: grants alternate 0,1,0,1.
    bus.Req0 = 1'b1;
    bus.Req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.Data0 = 16'h1000 + 16'(k);
      bus.Data1 = 16'h2000 + 16'(k);
      serveFrame(5 + k, 1'b0, 1'b0, g);
      check("rr_order", 32'(g), 32'(k % 2));
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;

    // SpiDone on the last timeout cycle counts as done; Req dropped after grant.
    bus.Req0  = 1'b1;
    bus.Data0 = 16'hBEEF;
    serveFrame(TIMEOUT - 1, 1'b1, 1'b0, g);

    // Reset during WAIT_DONE with Req0 held.
    bus.Req0  = 1'b1;
    bus.Data0 = 16'h3C5A;
    tick();
    tick();
    check("pre_rst_start", 32'(bus.SpiStart), 32'd1);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs",
          32'({bus.Ack0, bus.Ack1, bus.TimeoutErr, bus.SpiStart, bus.Busy, bus.GrantId}),
          32'd0);
    check("midrst_spidata", 32'(bus.SpiData), 32'd0);
    bus.SpiDone = 1'b1;
    tick();
    bus.SpiDone = 1'b0;
    check("midrst_noack", 32'({bus.Ack0, bus.Ack1}), 32'd0);
    reset_n   = 1'b1;
    modelLast = 1'b1;
    bus.Data0 = 16'h1234;
    serveFrame(10, 1'b0, 1'b0, g);
    bus.Req0 = 1'b0;

    // Randomized frames against the model.
    for (int n = 0; n < 16; n++) begin
      int r;
      int d;
      if (!bus.Req0 && ($urandom_range(0, 1) == 1)) begin
        bus.Req0  = 1'b1;
        bus.Data0 = 16'($urandom);
      end
      if (!bus.Req1 && ($urandom_range(0, 1) == 1)) begin
        bus.Req1  = 1'b1;
        bus.Data1 = 16'($urandom);
      end
      if (!bus.Req0 && !bus.Req1) begin
        if ($urandom_range(0, 1) == 1) bus.Req1 = 1'b1;
        else                           bus.Req0 = 1'b1;
      end
      r = int'($urandom_range(0, 9));
      if (r == 0)      d = 0;
      else if (r == 1) d = TIMEOUT - 1;
      else             d = int'($urandom_range(1, 40));
      serveFrame(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), g);
      // The served requester may stay high (a fresh request) or drop.
      if ($urandom_range(0, 1) == 1) begin
        if (g) bus.Req1 = 1'b0;
        else   bus.Req0 = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
